hazard_scheduler: RTL
=====================

Name: hazard_scheduler

Overview:
Central hazard and sequencing controller for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB).
- Keeps an internal scoreboard of destination registers in flight in EX, MEM and WB.
- From it, generates PC hold, IF_ID Stall/Flush, the ID_EX bubble and the EX-stage forwarding selects.
- Runs the halt/drain sequence that ends simulation once the pipeline is empty.

Parameters:
DRAIN_CYCLES, 4, cycles after halt acceptance before halt_done asserts (EX+MEM+WB+1)
HALT_WORD, 32'hFFFF_FFFF, instruction word in ID treated as halt

Ports:
CLOCK  in  1  pipeline clock, all state updates on posedge
RESET  in  1  synchronous active-high reset
inst_D  in  32  instruction currently in ID (IF_ID output)
rs_D  in  5  rs field of ID instruction
rt_D  in  5  rt field of ID instruction
uses_rs_D  in  1  ID instruction reads rs
uses_rt_D  in  1  ID instruction reads rt
RegWrite_D  in  1  ID instruction writes a register
MemtoReg_D  in  1  ID instruction is a load
dest_D  in  5  final destination register (post RegDst / jal=31)
Jump_D  in  1  ID instruction is j/jal/jr
branch_taken_E  in  1  branch in EX resolved taken this cycle
Stall_F  out  1  hold PC
Stall_D  out  1  to IF_ID Stall
Flush_D  out  1  to IF_ID Flush
Bubble_E  out  1  ID_EX loads zero controls next edge
fwdA_E  out  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
fwdB_E  out  2  EX operand B select, same encoding
halt_done  out  1  pipeline drained, sticky until RESET

Behaviour:
- Scoreboard: three entries E, M, W, each {valid, regwrite, memtoreg, dest, rs, rt}. Each posedge: W<=M, M<=E, E<=ID fields. E<=invalid when Bubble_E.
- RESET: all entries invalid, FSM=RUN, drain counter 0. Outputs Stall_F=Stall_D=Flush_D=Bubble_E=0, fwdA_E=fwdB_E=00, halt_done=0.
- RESET asserted mid-operation (including DRAIN/DONE): same reset state at the next edge.
- Load-use hazard (combinational), all conditions required:
  - E.valid & E.memtoreg & E.dest!=0
  - (uses_rs_D & rs_D==E.dest) | (uses_rt_D & rt_D==E.dest)
  - Response: Stall_F=Stall_D=Bubble_E=1 for exactly one cycle; the load moves to M and the hazard clears.
- Taken branch: branch_taken_E -> Flush_D=1 and Bubble_E=1 the same cycle (kills IF and ID instructions); Stall_F=Stall_D=0.
  - Branch flush overrides any simultaneous load-use stall.
- Jump: Jump_D & no load-use stall -> Flush_D=1 (kills the fall-through fetch); no bubble.
  - Jump_D while load-use stalled -> no flush until the stall clears.
- Forwarding (for instruction in E):
  - fwdA_E=10 if M.valid & M.regwrite & M.dest!=0 & M.dest==E.rs;
  - else 01 if the same condition holds on W;
  - else 00.
  - fwdB_E likewise on E.rt. MEM has priority over WB. $0 never forwards.
- FSM states RUN, DRAIN, DONE:
  - RUN->DRAIN when inst_D==HALT_WORD & !branch_taken_E; halt inserted as bubble.
  - DRAIN: Stall_F=Stall_D=1, Bubble_E=1; counter increments each cycle. When counter==DRAIN_CYCLES-1 -> DONE.
  - DONE: halt_done=1, Stall_F=Stall_D=Bubble_E=1, stays until RESET.
  - Halt in ID with branch_taken_E in the same cycle: flush wins, halt discarded, remain RUN.
- Priority per cycle: RESET > DRAIN/DONE > branch flush > load-use stall > jump flush.

Optional Feature:
HAZARD_FORWARD_EN
- Defined: forwarding as above; stall only on load-use.
- Undefined: fwdA_E=fwdB_E=00 constant. Stall (Stall_F=Stall_D=Bubble_E=1) on any RAW where the ID source matches a valid regwrite dest!=0 in E or M. No stall against W (register file writes before read).

Test Plan:
- lw $8,0($0) then add $9,$8,$8 -> one cycle Stall_F=Stall_D=Bubble_E=1; next cycle fwdA_E=fwdB_E=01.
- add $8,.. then sub $10,$8,$3 -> no stall; fwdA_E=10, fwdB_E=00. Without HAZARD_FORWARD_EN: 2 stall cycles, fwd=00.
- beq taken in EX while ID holds a load-use dependent instruction -> Flush_D=1, Bubble_E=1, Stall_D=0 that cycle.
- j in ID -> Flush_D=1 one cycle, Bubble_E=0. Writes to $0 followed by a $0 reader -> never forward, never stall.
- HALT_WORD in ID -> DRAIN; halt_done rises exactly 4 cycles later, stays 1. RESET in the DRAIN second cycle -> all outputs 0 next edge.

Source files
------------

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - 5-stage pipeline hazard scoreboard, stall/flush/forward control, halt drain.
// Optional feature macro: HAZARD_FORWARD_EN (EX-stage forwarding; otherwise stall on any EX/MEM RAW).
module hazard_scheduler #(
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] inst_D,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic        uses_rs_D,
  input  logic        uses_rt_D,
  input  logic        RegWrite_D,
  input  logic        MemtoReg_D,
  input  logic [4:0]  dest_D,
  input  logic        Jump_D,
  input  logic        branch_taken_E,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Flush_D,
  output logic        Bubble_E,
  output logic [1:0]  fwdA_E,
  output logic [1:0]  fwdB_E,
  output logic        halt_done
);

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] dest;
    logic [4:0] rs;
    logic [4:0] rt;
  } entry_t;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  localparam int unsigned   CW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  entry_t        e_q, m_q, w_q;
  entry_t        e_next;
  state_t        state;
  logic [CW-1:0] cnt;
  logic          hit_e;
  logic          hazard;
  logic          halt_D;
  logic          unused_ok;

  assign hit_e  = (uses_rs_D && rs_D == e_q.dest) || (uses_rt_D && rt_D == e_q.dest);
  assign halt_D = (state == RUN) && (inst_D == HALT_WORD) && !branch_taken_E;
  assign unused_ok = ^{e_q, m_q, w_q};

`ifdef HAZARD_FORWARD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hazard = e_q.valid && e_q.memtoreg && (e_q.dest != 5'd0) && hit_e;

  function automatic logic [1:0] fwd_sel(input entry_t m, input entry_t w, input logic [4:0] src);
    if (m.valid && m.regwrite && m.dest != 5'd0 && m.dest == src) return 2'b10;
    if (w.valid && w.regwrite && w.dest != 5'd0 && w.dest == src) return 2'b01;
    return 2'b00;
  endfunction

  assign fwdA_E = RESET ? 2'b00 : fwd_sel(m_q, w_q, e_q.rs);
  assign fwdB_E = RESET ? 2'b00 : fwd_sel(m_q, w_q, e_q.rt);
`else
  logic hit_m;
  assign hit_m  = (uses_rs_D && rs_D == m_q.dest) || (uses_rt_D && rt_D == m_q.dest);
  // WB is excluded: the register file writes before it is read.
  assign hazard = (e_q.valid && e_q.regwrite && (e_q.dest != 5'd0) && hit_e) ||
                  (m_q.valid && m_q.regwrite && (m_q.dest != 5'd0) && hit_m);
  assign fwdA_E = 2'b00;
  assign fwdB_E = 2'b00;
`endif

  always_comb begin
    Stall_F   = 1'b0;
    Stall_D   = 1'b0;
    Flush_D   = 1'b0;
    Bubble_E  = 1'b0;
    halt_done = 1'b0;
    if (RESET) begin
      Stall_F = 1'b0;
    end else if (state != RUN) begin
      Stall_F   = 1'b1;
      Stall_D   = 1'b1;
      Bubble_E  = 1'b1;
      halt_done = (state == DONE);
    end else if (branch_taken_E) begin
      Flush_D  = 1'b1;
      Bubble_E = 1'b1;
    end else if (halt_D || hazard) begin
      Stall_F  = 1'b1;
      Stall_D  = 1'b1;
      Bubble_E = 1'b1;
    end else if (Jump_D) begin
      Flush_D = 1'b1;
    end
  end

  always_comb begin
    e_next = '0;
    if (!Bubble_E) begin
      e_next = '{valid: 1'b1, regwrite: RegWrite_D, memtoreg: MemtoReg_D,
                 dest: dest_D, rs: rs_D, rt: rt_D};
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      state <= RUN;
      cnt   <= '0;
    end else begin
      w_q <= m_q;
      m_q <= e_q;
      e_q <= e_next;
      case (state)
        RUN: begin
          if (halt_D) begin
            state <= DRAIN;
            cnt   <= '0;
          end
        end
        DRAIN: begin
          if (cnt == CNT_LAST) state <= DONE;
          else                 cnt   <= cnt + 1'b1;
        end
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

endmodule
